// File: rtl/user_input_fifo.sv
// user_input_fifo: valid/ack buffered FIFO between a leaf interface and a user kernel input stream
module user_input_fifo #(
  parameter int PAYLOAD_BITS      = 32,
  parameter int DEPTH_BITS        = 4,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din_leaf_interface2fifo,
  input  logic                    vld_interface2fifo,
  output logic                    ack_fifo2interface,
  output logic [PAYLOAD_BITS-1:0] dout_fifo2user,
  output logic                    vld_fifo2user,
  input  logic                    ack_user2fifo,
  input  logic                    flush,
  output logic [DEPTH_BITS:0]     count,
  output logic                    almost_full
);
  localparam logic [DEPTH_BITS:0] FULL = (DEPTH_BITS+1)'(1 << DEPTH_BITS);
  localparam logic [DEPTH_BITS:0] AF   = (DEPTH_BITS+1)'(ALMOST_FULL_LEVEL);
  logic [PAYLOAD_BITS-1:0] mem [1 << DEPTH_BITS];
  logic [DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]     count_q, count_d;
  logic                    wr, rd;
  // handshakes and outputs; reset gating keeps ack low while held in reset
  always_comb begin
    ack_fifo2interface = reset && (count_q != FULL) && !flush;
    vld_fifo2user      = count_q != '0;
    wr                 = vld_interface2fifo && ack_fifo2interface;
    rd                 = vld_fifo2user && ack_user2fifo && !flush;
    dout_fifo2user     = vld_fifo2user ? mem[rd_ptr_q] : '0;
    count              = count_q;
    almost_full        = count_q >= AF;
  end
  // next pointer and occupancy; flush clears everything and discards transfers
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + DEPTH_BITS'(wr);
    rd_ptr_d = flush ? '0 : rd_ptr_q + DEPTH_BITS'(rd);
    count_d  = flush ? '0 : count_q + (DEPTH_BITS+1)'(wr) - (DEPTH_BITS+1)'(rd);
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // storage array, not reset; stale words are masked by count
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= din_leaf_interface2fifo;
  end
endmodule

// File: tb/tb_user_input_fifo.sv
// tb_user_input_fifo: randomized self-checking bench against a queue reference model
module tb_user_input_fifo;
  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] din = 0;
  logic        vld_in = 0;
  logic        ack_in;
  logic [31:0] dout;
  logic        vld_out;
  logic        ack_u = 0;
  logic        flush = 0;
  logic [4:0]  count;
  logic        almost_full;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] q[$];

  user_input_fifo dut (
    .clk(clk), .reset(reset), .din_leaf_interface2fifo(din), .vld_interface2fifo(vld_in),
    .ack_fifo2interface(ack_in), .dout_fifo2user(dout), .vld_fifo2user(vld_out),
    .ack_user2fifo(ack_u), .flush(flush), .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic exp_ack);
    logic [31:0] exp_dout;
    exp_dout = q.size() > 0 ? q[0] : 32'h0;
    check("ack", 32'(ack_in), 32'(exp_ack));
    check("vld", 32'(vld_out), 32'(q.size() > 0));
    check("dout", dout, exp_dout);
    check("count", 32'(count), q.size());
    check("almost_full", 32'(almost_full), 32'(q.size() >= 12));
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic a, input logic f, output logic acc);
    logic exp_ack, exp_vld;
    @(negedge clk);
    vld_in = v; din = d; ack_u = a; flush = f;
    #1;
    exp_ack = q.size() < 16 && !f;
    exp_vld = q.size() > 0;
    check_outputs(exp_ack);
    acc = v && exp_ack;
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (exp_vld && a) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
  endtask

  task automatic reset_check;
    #1;
    check("rst_ack", 32'(ack_in), 0);
    check("rst_vld", 32'(vld_out), 0);
    check("rst_dout", dout, 0);
    check("rst_count", 32'(count), 0);
    check("rst_af", 32'(almost_full), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [31:0] w;
    int sent, cycles;
    #1 reset = 0;
    reset_check();
    #20 reset = 1;
    // first cycle after release accepts
    cyc(1, 32'hDEADBEEF, 0, 0, acc);
    check("single_acc", 32'(acc), 1);
    cyc(0, 0, 0, 0, acc);
    cyc(0, 0, 1, 0, acc);
    cyc(0, 0, 1, 0, acc);
    // fill 0..15, then the 17th word is held upstream
    for (int i = 0; i < 16; i++) cyc(1, i, 0, 0, acc);
    cyc(1, 16, 0, 0, acc);
    check("full_hold", 32'(acc), 0);
    cyc(1, 16, 1, 0, acc);
    check("full_rw_write", 32'(acc), 0);
    cyc(1, 16, 0, 0, acc);
    check("after_full_write", 32'(acc), 1);
    for (int i = 1; i <= 16; i++) begin
      #1 check("order", dout, i);
      cyc(0, 0, 1, 0, acc);
    end
    cyc(0, 0, 1, 0, acc);
    // random stream with stalls on both sides
    sent = 0; cycles = 0; w = $urandom;
    while ((sent < 40 || q.size() > 0) && cycles < 1000) begin
      cyc(sent < 40 && ($urandom % 4 != 0), w, $urandom % 3 != 0, 0, acc);
      if (acc) begin sent++; w = $urandom; end
      cycles++;
    end
    check("stream_done", 32'(sent), 40);
    check("stream_drained", q.size(), 0);
    // flush at count 7 with a concurrent write and read
    for (int i = 0; i < 7; i++) cyc(1, 32'h100 + i, 0, 0, acc);
    cyc(1, 32'hAAAA5555, 1, 1, acc);
    check("flush_drop", 32'(acc), 0);
    cyc(0, 0, 1, 0, acc);
    cyc(0, 0, 0, 0, acc);
    // asynchronous reset between edges with count 5
    for (int i = 0; i < 5; i++) cyc(1, 32'h200 + i, 0, 0, acc);
    #2 reset = 0;
    q.delete();
    reset_check();
    #1 reset = 1;
    cyc(1, 32'h12345678, 0, 0, acc);
    cyc(0, 0, 1, 0, acc);
    cyc(0, 0, 0, 0, acc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/user_input_fifo.md
USER_INPUT_FIFO -- requirements
Module: user_input_fifo

Interface
REQ-001 The module SHALL have parameter PAYLOAD_BITS, default 32: width of each data word.
REQ-002 The module SHALL have parameter DEPTH_BITS, default 4: log2 of storage depth, so the default depth is 16 words.
REQ-003 The module SHALL have parameter ALMOST_FULL_LEVEL, default 12: occupancy at or above which almost_full asserts.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port din_leaf_interface2fifo, input, PAYLOAD_BITS: write data from the leaf interface.
REQ-007 The module SHALL have port vld_interface2fifo, input, 1 bit: write data valid.
REQ-008 The module SHALL have port ack_fifo2interface, output, 1 bit: write accepted.
REQ-009 The module SHALL have port dout_fifo2user, output, PAYLOAD_BITS: head word to the user kernel Input_*_V_V.
REQ-010 The module SHALL have port vld_fifo2user, output, 1 bit: head word valid, driving Input_*_V_V_ap_vld.
REQ-011 The module SHALL have port ack_user2fifo, input, 1 bit: head word consumed, from Input_*_V_V_ap_ack.
REQ-012 The module SHALL have port flush, input, 1 bit: synchronous clear of contents.
REQ-013 The module SHALL have port count, output, DEPTH_BITS+1: current occupancy, 0 to 2^DEPTH_BITS.
REQ-014 The module SHALL have port almost_full, output, 1 bit: asserted when count >= ALMOST_FULL_LEVEL.

Function
REQ-015 A write SHALL occur in a cycle where vld_interface2fifo = 1 and ack_fifo2interface = 1, sampled at the rising edge.
REQ-016 A read SHALL occur in a cycle where vld_fifo2user = 1 and ack_user2fifo = 1, sampled at the rising edge.
REQ-017 ack_fifo2interface SHALL be 1 exactly when count < 2^DEPTH_BITS and flush = 0; it SHALL be a combinational function of registered state and flush only, never of vld_interface2fifo.
REQ-018 vld_fifo2user SHALL be 1 exactly when count > 0.
REQ-019 dout_fifo2user SHALL present the oldest stored word whenever vld_fifo2user = 1, and SHALL hold that value until the word is read.
REQ-020 Write-to-output latency SHALL be 1 cycle: a word written at edge N into an empty FIFO has vld_fifo2user = 1 in the cycle following edge N; there is no same-cycle bypass.
REQ-021 Write and read pointers SHALL be DEPTH_BITS wide, increment by 1 per transfer, and wrap from 2^DEPTH_BITS-1 to 0.
REQ-022 On a simultaneous write and read, count SHALL be unchanged, both pointers SHALL advance, and data order SHALL be preserved.
REQ-023 When full, no write SHALL occur even if a read happens in the same cycle; the write may occur in the next cycle.
REQ-024 When empty, ack_user2fifo SHALL have no effect.
REQ-025 flush = 1 at an edge SHALL set the pointers and count to 0; a write and a read in that cycle SHALL be discarded; flush SHALL take priority over both.
REQ-026 The ack_user2fifo input SHALL be ignored when vld_fifo2user = 0; no underflow SHALL be possible.
REQ-027 almost_full SHALL be registered-consistent with count, updating in the same cycle count changes.
REQ-028 Data SHALL be stored in an inferred memory array of 2^DEPTH_BITS x PAYLOAD_BITS.

Reset
REQ-029 While reset = 0, asynchronously: count = 0, both pointers = 0, vld_fifo2user = 0, ack_fifo2interface = 0, almost_full = 0, dout_fifo2user = 0.
REQ-030 After reset deasserts, ack_fifo2interface SHALL be 1 in the first cycle, provided flush = 0.
REQ-031 Reset asserted mid-transfer SHALL discard all contents; memory contents need not be cleared, but no stale word SHALL ever be presented valid.

Verification
REQ-032 Test single word: after reset, write 0xDEADBEEF with ack_user2fifo = 0 -> next cycle vld_fifo2user = 1, dout = 0xDEADBEEF, count = 1.
REQ-033 Test fill: write 16 words 0..15 with the user side stalled -> count = 16, ack_fifo2interface = 0, almost_full = 1 from count 12; the 17th word is held by the upstream, not lost.
REQ-034 Test simultaneous read/write when full: with the FIFO full, a write and a read in the same cycle -> the read occurs, count = 15, the write is not accepted; on the next cycle the write is accepted, count = 16, and the order is 1..15, 16.
REQ-035 Test wrap: stream 40 words with random vld/ack stalls -> the output sequence equals the input sequence and the pointers wrap at least twice.
REQ-036 Test flush: with count = 7, flush for 1 cycle with vld_interface2fifo = 1 -> count = 0, vld_fifo2user = 0, and the concurrent word is dropped.
REQ-037 Test reset: assert reset asynchronously between edges with count = 5 -> all outputs reach their reset values immediately, and after release count = 0.
